// File: rtl/dvfs_pkg.sv
// dvfs_pkg: divider state encoding and default selector width shared with the DVFS controller
package dvfs_pkg;
  localparam int DVFS_DIV_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} dvfs_state_t;
endpackage

// File: rtl/dvfs_clock_divider.sv
// dvfs_clock_divider: glitch-free runtime-programmable clock divider, ratio changes land on a falling edge
module dvfs_clock_divider
  import dvfs_pkg::*;
#(
  parameter int DIV_W     = DVFS_DIV_W,
  parameter int RESET_DIV = 1
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             req_valid,
  input  logic [DIV_W-1:0] req_div,
  output logic             req_ready,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);
  dvfs_state_t      state, state_n;
  logic [DIV_W-1:0] count, count_n, cur_div_n, pending_div, pending_div_n;
  logic             run_cnt, hit, toggle, fall, apply, accept, clk_out_n, busy_n;
  always_comb begin
    run_cnt       = state == RUN || (state == STOPPING && (enable || clk_out));
    hit           = count == cur_div;
    toggle        = run_cnt && hit;
    fall          = toggle && clk_out;
    apply         = busy && (state == IDLE || fall);
    accept        = req_valid && !busy;
    count_n       = (run_cnt && !hit) ? count + 1'b1 : '0;
    clk_out_n     = clk_out ^ toggle;
    cur_div_n     = apply ? pending_div : cur_div;
    pending_div_n = accept ? req_div : pending_div;
    busy_n        = accept || (busy && !apply);
    // a low phase while stopping parks immediately; a high phase runs to its falling edge first
    state_n       = enable ? RUN :
                    (state == IDLE || (state == STOPPING && (!clk_out || fall))) ? IDLE : STOPPING;
  end
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      clk_out     <= 1'b0;
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
      cur_div     <= DIV_W'(RESET_DIV);
      pending_div <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      clk_out     <= clk_out_n;
      rise_tick   <= toggle && !clk_out;
      fall_tick   <= fall;
      cur_div     <= cur_div_n;
      pending_div <= pending_div_n;
      busy        <= busy_n;
    end
  end
  assign req_ready = !busy;
endmodule

// File: tb/tb_dvfs_clock_divider.sv
// tb_dvfs_clock_divider: directed checks of divide ratios, ratio changes, stopping and reset
module tb_dvfs_clock_divider;
  logic       clk_in = 1'b0;
  logic       reset_n, enable, req_valid, req_ready, clk_out, rise_tick, fall_tick, busy;
  logic [3:0] req_div, cur_div;
  logic [31:0] c, r, f;
  int n_chk = 0;
  int n_pass = 0;

  dvfs_clock_divider #(.DIV_W(4), .RESET_DIV(1)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .req_valid(req_valid),
    .req_div(req_div), .req_ready(req_ready), .clk_out(clk_out), .rise_tick(rise_tick),
    .fall_tick(fall_tick), .cur_div(cur_div), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run(input int n, output logic [31:0] cv, output logic [31:0] rv, output logic [31:0] fv);
    cv = '0; rv = '0; fv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      cv = {cv[30:0], clk_out};
      rv = {rv[30:0], rise_tick};
      fv = {fv[30:0], fall_tick};
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; req_valid = 1'b0; req_div = '0;
    repeat (3) @(negedge clk_in);
    check("rst_clk", clk_out, 0);
    check("rst_rise", rise_tick, 0);
    check("rst_fall", fall_tick, 0);
    check("rst_div", cur_div, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    reset_n = 1'b1; enable = 1'b1;
    run(11, c, r, f);
    check("div4_clk", c, 11'b00110011001);
    check("div4_rise", r, 11'b00100010001);
    check("div4_fall", f, 11'b00001000100);
    req_valid = 1'b1; req_div = 4'd3;
    @(negedge clk_in);
    req_valid = 1'b0;
    check("chg_busy", busy, 1);
    check("chg_ready", req_ready, 0);
    check("chg_olddiv", cur_div, 1);
    check("chg_high", clk_out, 1);
    @(negedge clk_in);
    check("apl_busy", busy, 0);
    check("apl_ready", req_ready, 1);
    check("apl_div", cur_div, 3);
    check("apl_fall", fall_tick, 1);
    run(12, c, r, f);
    check("div8_clk", c, 12'b000111100001);
    enable = 1'b0;
    run(7, c, r, f);
    check("stop_clk", c, 7'b1110000);
    check("stop_fall", f, 7'b0001000);
    check("stop_rise", r, 0);
    check("stop_div", cur_div, 3);
    req_valid = 1'b1; req_div = 4'd0;
    @(negedge clk_in);
    req_valid = 1'b0;
    check("idle_busy", busy, 1);
    check("idle_olddiv", cur_div, 3);
    @(negedge clk_in);
    check("idle_div", cur_div, 0);
    check("idle_busy0", busy, 0);
    check("idle_ready", req_ready, 1);
    enable = 1'b1;
    run(8, c, r, f);
    check("div2_clk", c, 8'b01010101);
    check("div2_rise", r, 8'b01010101);
    check("div2_fall", f, 8'b00101010);
    req_valid = 1'b1; req_div = 4'd2;
    @(negedge clk_in);
    req_div = 4'd5;
    check("b2b_ready0", req_ready, 0);
    @(negedge clk_in);
    check("b2b_stall", req_ready, 0);
    check("b2b_div0", cur_div, 0);
    @(negedge clk_in);
    check("b2b_div2", cur_div, 2);
    check("b2b_ready1", req_ready, 1);
    @(negedge clk_in);
    req_valid = 1'b0;
    check("b2b_busy2", busy, 1);
    run(11, c, r, f);
    check("b2b_clk", c, 11'b01110000001);
    check("b2b_div5", cur_div, 5);
    req_valid = 1'b1; req_div = 4'd7;
    @(negedge clk_in);
    req_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_clk", clk_out, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_clk", clk_out, 0);
    check("arst_busy", busy, 0);
    check("arst_div", cur_div, 1);
    check("arst_ready", req_ready, 1);
    @(negedge clk_in);
    reset_n = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk_in);
    check("post_div", cur_div, 1);
    check("post_clk", clk_out, 0);
    check("post_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dvfs_clock_divider.md
# dvfs_clock_divider

Runtime-programmable clock divider for the DVFS path: it derives a divided core clock and matching single-cycle tick strobes from the fast input clock. The divide ratio can be changed while the output is running, via a valid/ready request from the DVFS controller. A new ratio takes effect only at a phase boundary, so no runt pulse or shortened phase ever appears on `clk_out`. It sits between the system PLL clock and the core clock mux/enable logic and supersedes the fixed divide-by-N counter.

## Interface
- `DIV_W`, 4: width of the divide selector. Half-period = `div`+1 input cycles, so the output period is 2·(`div`+1).
- `RESET_DIV`, 1: `cur_div` value out of reset. The default gives ÷4.

Ports:
- `clk_in` in 1: single input clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request for the divided clock.
- `req_valid` in 1: new divide value offered.
- `req_div` in `DIV_W`: requested divide selector.
- `req_ready` out 1: a request can be accepted.
- `clk_out` out 1: divided clock, registered.
- `rise_tick` out 1: one `clk_in` cycle, high in the first cycle `clk_out` is high.
- `fall_tick` out 1: one `clk_in` cycle, high in the first cycle `clk_out` is low after a high phase.
- `cur_div` out `DIV_W`: divide selector currently in force.
- `busy` out 1: a request is accepted but not yet applied.

## Operation
Reset values:
- `clk_out`=0, ticks=0, `count`=0.
- `cur_div`=`RESET_DIV`, `busy`=0, `req_ready`=1.
- State = IDLE.

States:
- IDLE: `clk_out`=0, `count` held at 0. Goes to RUN when `enable`=1.
- RUN: `count` increments each cycle. When `count`==`cur_div`: `count`←0 and `clk_out` toggles. Goes to STOPPING when `enable`=0.
- STOPPING: keeps counting.
  - If `clk_out`=1, completes the current high phase, drops `clk_out`, then goes to IDLE.
  - If `clk_out`=0, goes to IDLE immediately.
  - If `enable` returns to 1 in STOPPING, goes back to RUN with no phase disturbance.

Ratio change:
- Handshake: accept when `req_valid`&&`req_ready`. `pending_div`←`req_div`, `busy`←1, `req_ready`←0.
- Apply point in RUN/STOPPING: the cycle where `clk_out` toggles 1→0. On that edge `cur_div`←`pending_div` and `count`←0, so the following low phase already uses the new ratio.
- Apply point in IDLE: the next edge.
- After apply: `busy`←0 and `req_ready`←1, registered, one cycle after apply. Requests are therefore accepted at most once per two cycles.
- The high phase in progress always completes with the old ratio. Every half-phase is ≥ `min`(old,new)+1 cycles, so the output is glitch-free.

Other rules:
- `req_div`=0 is legal and gives ÷2; `clk_out` toggles every cycle.
- A request offered while `busy`=1 is not accepted; `req_valid` must be held.
- `count` is `DIV_W` bits and never exceeds `cur_div`. There is no wrap beyond the all-ones value.

## Timing
- From the edge where state becomes RUN, the first `clk_out` rise comes `cur_div`+1 edges later.
- Thereafter `clk_out` is high for `cur_div`+1 cycles and low for `cur_div`+1 cycles.
- `rise_tick`/`fall_tick` are registered and coincide with the `clk_out` transition cycle. Zero latency relative to `clk_out`.
- Request-to-apply latency:
  - IDLE: 1 cycle.
  - RUN: ≤ 2·(`cur_div`+1) cycles.
- Simultaneous apply and `enable` drop: the apply happens, then the stop is evaluated with the new ratio.
- Reset mid-operation: all outputs return to reset values asynchronously. Any pending request is discarded.

## Structure
- Shared package `dvfs_pkg`: state enum (IDLE/RUN/STOPPING) and `DIV_W` default constant, shared with the DVFS controller.
- Single module, no sub-modules. The request register and phase counter are small enough to sit inline.

## Test plan
- Reset, `enable`=1, `RESET_DIV`=1 → first `clk_out` rise 2 cycles after entering RUN, then period 4 (2 high/2 low). `rise_tick` pulses every 4 cycles.
- Mid-high-phase request `req_div`=3 from `div`=1 → current high lasts 2 cycles, next low lasts 4 cycles, then period 8. `busy` is high until the apply edge; `req_ready` returns the cycle after.
- `req_div`=0 in IDLE → applied on the next edge. With `enable`, `clk_out` toggles every cycle (÷2), and there is no phase shorter than 1 cycle.
- `enable` dropped one cycle into a 4-cycle high phase (`div`=3) → `clk_out` stays high 3 more cycles, falls with `fall_tick`, then parks low in IDLE.
- Back-to-back `req_valid` with values 2 then 5 → the second request is stalled (`req_ready`=0) until the first is applied. The phases observed are 3-cycle, then 6-cycle.
- `reset_n` asserted while `busy`=1 and `clk_out`=1 → immediately `clk_out`=0, `busy`=0, `cur_div`=`RESET_DIV`, `req_ready`=1.
